// File: rtl/mel_spec_store.sv
// Log-mel frame store: keeps the newest N_FRAMES frames in a ring and streams
// them out oldest-first through a two-entry prefetch buffer.
module mel_spec_store #(
  parameter int WIDTH           = 16,
  parameter int N_FRAMES        = 101,
  parameter int MEL_BANDS       = 40,
  parameter int SPEC_ADDR_WIDTH = $clog2(N_FRAMES*MEL_BANDS),
  parameter int FCNT_WIDTH      = $clog2(N_FRAMES+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  mel_avail,
  input  logic [WIDTH-1:0]      mel_data,
  input  logic                  rd_start,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_last,
  output logic                  rd_busy,
  output logic                  spec_full,
  output logic [FCNT_WIDTH-1:0] frame_cnt,
  output logic                  frame_done,
  output logic                  overrun
);

  localparam int TOTAL = N_FRAMES * MEL_BANDS;
  localparam int BW    = (MEL_BANDS > 1) ? $clog2(MEL_BANDS) : 1;
  localparam int CW    = SPEC_ADDR_WIDTH + 1;
  localparam logic [SPEC_ADDR_WIDTH-1:0] LAST_ADDR = SPEC_ADDR_WIDTH'(TOTAL - 1);
  localparam logic [CW-1:0]              TOTAL_C   = CW'(TOTAL);
  localparam logic [BW-1:0]              LAST_BAND = BW'(MEL_BANDS - 1);
  localparam logic [FCNT_WIDTH-1:0]      NF_C      = FCNT_WIDTH'(N_FRAMES);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, DUMP = 2'd2} state_t;

  state_t state, state_nxt;
  logic [WIDTH-1:0] mem [0:TOTAL-1];

  logic                       clear, wr_en, band_wrap;
  logic [BW-1:0]              wr_band;
  logic [SPEC_ADDR_WIDTH-1:0] wr_addr, f_addr;
  logic [CW-1:0]              fl, rl, wl;
  logic                       start_acc, arm_fire, in_dump;
  logic [WIDTH-1:0]           ram_q, sk_data;
  logic                       ram_v, ram_last, sk_v, sk_last;
  logic                       pop, issue;
  logic [1:0]                 occ;

  assign clear     = rst | clr;
  assign wr_en     = mel_avail & ~clear;
  assign band_wrap = wr_en & (wr_band == LAST_BAND);
  assign pop       = rd_valid & rd_ready;
  assign occ       = {1'b0, ram_v} + {1'b0, rd_valid} + {1'b0, sk_v};
  // Fetch only when the word still fits after everything in flight lands.
  assign issue     = in_dump & (fl != TOTAL_C) & ((occ - {1'b0, pop}) <= 2'd1);

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_band    <= '0;
      wr_addr    <= '0;
      frame_cnt  <= '0;
      spec_full  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= band_wrap;
      if (wr_en) begin
        wr_band <= band_wrap ? '0 : wr_band + BW'(1);
        wr_addr <= (wr_addr == LAST_ADDR) ? '0 : wr_addr + SPEC_ADDR_WIDTH'(1);
      end
      if (band_wrap && (frame_cnt != NF_C)) begin
        frame_cnt <= frame_cnt + FCNT_WIDTH'(1);
        spec_full <= (frame_cnt == NF_C - FCNT_WIDTH'(1));
      end
    end
  end

  // Read-first RAM: a same-cycle write to the fetched address yields old data.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= mel_data;
    if (issue) ram_q <= mem[f_addr];
  end

  always_ff @(posedge clk) begin
    if (clear) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rd_start && spec_full) state_nxt = ARMED;
      ARMED:   if ((wr_band == '0) && !mel_avail) state_nxt = DUMP;
      DUMP:    if (pop && rd_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_busy   = 1'b0;
    start_acc = 1'b0;
    arm_fire  = 1'b0;
    in_dump   = 1'b0;
    case (state)
      IDLE:    start_acc = rd_start & spec_full;
      ARMED: begin
        rd_busy  = 1'b1;
        arm_fire = (wr_band == '0) & ~mel_avail;
      end
      DUMP: begin
        rd_busy = 1'b1;
        in_dump = 1'b1;
      end
      default: rd_busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      f_addr   <= '0;
      fl       <= '0;
      rl       <= '0;
      wl       <= '0;
      overrun  <= 1'b0;
      ram_v    <= 1'b0;
      ram_last <= 1'b0;
      sk_v     <= 1'b0;
      sk_data  <= '0;
      sk_last  <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_last  <= 1'b0;
    end else begin
      if (start_acc) overrun <= 1'b0;
      else if (in_dump && mel_avail && (wl >= rl)) overrun <= 1'b1;

      // The oldest frame starts where the next write would land.
      if (arm_fire) begin
        f_addr <= wr_addr;
        fl     <= '0;
        rl     <= '0;
        wl     <= '0;
      end else if (in_dump) begin
        if (issue) begin
          f_addr <= (f_addr == LAST_ADDR) ? '0 : f_addr + SPEC_ADDR_WIDTH'(1);
          fl     <= fl + CW'(1);
        end
        if (pop) rl <= rl + CW'(1);
        if (mel_avail && (wl != TOTAL_C)) wl <= wl + CW'(1);
      end

      ram_v    <= issue;
      ram_last <= (fl == TOTAL_C - CW'(1));

      // Output register is the FIFO head, skid register the second entry.
      if (pop) begin
        rd_valid <= sk_v | ram_v;
        if (sk_v) begin
          rd_data <= sk_data;
          rd_last <= sk_last;
          sk_v    <= ram_v;
          sk_data <= ram_q;
          sk_last <= ram_last;
        end else if (ram_v) begin
          rd_data <= ram_q;
          rd_last <= ram_last;
        end else begin
          rd_last <= 1'b0;
        end
      end else if (!rd_valid) begin
        if (ram_v) begin
          rd_valid <= 1'b1;
          rd_data  <= ram_q;
          rd_last  <= ram_last;
        end
      end else if (!sk_v && ram_v) begin
        sk_v    <= 1'b1;
        sk_data <= ram_q;
        sk_last <= ram_last;
      end
    end
  end

endmodule

// File: tb/tb_mel_spec_store.sv
// Randomized self-checking bench for mel_spec_store against an array model of
// the frame ring and the oldest-first dump order.
module tb_mel_spec_store;

  localparam int W     = 16;
  localparam int NF    = 101;
  localparam int MB    = 40;
  localparam int TOTAL = NF * MB;
  localparam int FCW   = $clog2(NF + 1);

  logic           clk = 1'b0;
  logic           rst, clr, mel_avail, rd_start, rd_ready;
  logic [W-1:0]   mel_data;
  logic           rd_valid, rd_last, rd_busy, spec_full, frame_done, overrun;
  logic [W-1:0]   rd_data;
  logic [FCW-1:0] frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  int mem_m [TOTAL];
  int wpos;
  int fcnt;

  mel_spec_store dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .mel_avail  (mel_avail),
    .mel_data   (mel_data),
    .rd_start   (rd_start),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .rd_last    (rd_last),
    .rd_busy    (rd_busy),
    .spec_full  (spec_full),
    .frame_cnt  (frame_cnt),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    wpos = 0;
    fcnt = 0;
  endtask

  // One band word; the model records it and predicts frame bookkeeping.
  task automatic wr(input logic [W-1:0] v);
    int  band;
    bit  done;
    mel_avail = 1'b1;
    mel_data  = v;
    tick();
    mel_avail = 1'b0;
    mem_m[wpos] = int'(v);
    band = wpos % MB;
    wpos = (wpos + 1) % TOTAL;
    done = (band == MB - 1);
    if (done && fcnt < NF) fcnt++;
    check_val("frame_done", 32'(frame_done), 32'(done));
    check_val("frame_cnt", 32'(frame_cnt), 32'(fcnt));
    check_val("spec_full", 32'(spec_full), 32'(fcnt == NF));
  endtask

  task automatic start_dump();
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    check_val("busy_rise", 32'(rd_busy), 32'd1);
  endtask

  // Drains max_k words; expected word k comes from frame (s + k/MB) mod NF.
  task automatic collect(input int mode, input bit chk_data, input int max_k);
    int k;
    int cyc;
    int s;
    int exp_v;
    k   = 0;
    cyc = 0;
    s   = wpos / MB;
    while (k < max_k && cyc < 30000) begin
      rd_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (rd_valid) begin
        exp_v = mem_m[((s + k / MB) % NF) * MB + (k % MB)];
        if (chk_data) check_val("dump_data", 32'(rd_data), 32'(exp_v[W-1:0]));
        check_val("dump_last", 32'(rd_last), 32'(k == TOTAL - 1));
        if (rd_ready) k++;
      end
      tick();
      cyc++;
    end
    rd_ready = 1'b0;
    check_val("dump_count", 32'(k), 32'(max_k));
    if (max_k == TOTAL) begin
      check_val("valid_drop", 32'(rd_valid), 32'd0);
      check_val("busy_drop", 32'(rd_busy), 32'd0);
    end
  endtask

  task automatic first_valid_latency(input string tag);
    check_val({tag, "_v0"}, 32'(rd_valid), 32'd0);
    tick();
    check_val({tag, "_v1"}, 32'(rd_valid), 32'd0);
    tick();
    check_val({tag, "_v2"}, 32'(rd_valid), 32'd0);
    tick();
    check_val({tag, "_v3"}, 32'(rd_valid), 32'd1);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; mel_avail = 1'b0; mel_data = '0;
    rd_start = 1'b0; rd_ready = 1'b0;
    tick();
    tick();
    check_val("rst_valid", 32'(rd_valid), 32'd0);
    check_val("rst_last", 32'(rd_last), 32'd0);
    check_val("rst_busy", 32'(rd_busy), 32'd0);
    check_val("rst_full", 32'(spec_full), 32'd0);
    check_val("rst_done", 32'(frame_done), 32'd0);
    check_val("rst_overrun", 32'(overrun), 32'd0);
    check_val("rst_fcnt", 32'(frame_cnt), 32'd0);
    check_val("rst_data", 32'(rd_data), 32'd0);
    rst = 1'b0;
    model_clear();

    // Fill with linear index, then dump with first-word latency check.
    for (int i = 0; i < TOTAL; i++) wr(W'(i));
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    check_val("fill_busy", 32'(rd_busy), 32'd1);
    tick();
    check_val("fill_v1", 32'(rd_valid), 32'd0);
    tick();
    check_val("fill_v2", 32'(rd_valid), 32'd0);
    tick();
    check_val("fill_v3", 32'(rd_valid), 32'd1);
    collect(0, 1'b1, TOTAL);

    // Wrap: 103 frames, oldest surviving frame is frame 2.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    for (int f = 0; f < 103; f++)
      for (int b = 0; b < MB; b++) wr(W'(f * MB + b));
    check_val("wrap_head", 32'(mem_m[wpos]), 32'd80);
    start_dump();
    collect(0, 1'b1, TOTAL);
    check_val("wrap_overrun", 32'(overrun), 32'd0);

    // Backpressure: same store, random ready.
    start_dump();
    collect(1, 1'b1, TOTAL);

    // Armed deferral: request at band 17, dump waits for frame end.
    for (int i = 0; i < 17; i++) wr(W'($urandom));
    rd_start = 1'b1;
    wr(W'($urandom));
    rd_start = 1'b0;
    for (int i = 0; i < 22; i++) begin
      check_val("armed_busy", 32'(rd_busy), 32'd1);
      check_val("armed_novalid", 32'(rd_valid), 32'd0);
      wr(W'($urandom));
    end
    first_valid_latency("armed");
    collect(0, 1'b1, TOTAL);

    // Overrun: write a frame while the dump is stalled.
    start_dump();
    repeat (5) tick();
    check_val("ovr_before", 32'(overrun), 32'd0);
    wr(W'($urandom));
    check_val("ovr_set", 32'(overrun), 32'd1);
    for (int i = 0; i < MB - 1; i++) wr(W'($urandom));
    collect(0, 1'b0, TOTAL);
    check_val("ovr_sticky", 32'(overrun), 32'd1);
    start_dump();
    check_val("ovr_cleared", 32'(overrun), 32'd0);
    collect(0, 1'b1, TOTAL);

    // Clear / ignore.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    model_clear();
    for (int i = 0; i < 50 * MB; i++) wr(W'($urandom));
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    check_val("ignore_busy", 32'(rd_busy), 32'd0);
    tick();
    check_val("ignore_valid", 32'(rd_valid), 32'd0);
    for (int i = 0; i < 51 * MB; i++) wr(W'($urandom));
    start_dump();
    repeat (4) tick();
    wr(W'($urandom));
    check_val("clr_ovr_pre", 32'(overrun), 32'd1);
    collect(1, 1'b0, 100);
    clr = 1'b1;
    mel_avail = 1'b1;
    mel_data = W'($urandom);
    tick();
    clr = 1'b0;
    mel_avail = 1'b0;
    model_clear();
    check_val("clr_valid", 32'(rd_valid), 32'd0);
    check_val("clr_busy", 32'(rd_busy), 32'd0);
    check_val("clr_fcnt", 32'(frame_cnt), 32'd0);
    check_val("clr_full", 32'(spec_full), 32'd0);
    check_val("clr_overrun", 32'(overrun), 32'd0);
    for (int i = 0; i < MB; i++) wr(W'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mel_spec_store.md
# mel_spec_store

Frame store and readout engine for the log-mel front end. It sits behind the mel filterbank stage and accepts the unthrottled `mel_avail`/`mel_data` band stream, one word per band, `MEL_BANDS` words per frame. It keeps the most recent `N_FRAMES` frames in a ring buffer. On request it dumps the whole spectrogram, oldest frame first, over a valid/ready stream to the downstream classifier.

## Interface

Parameters:
- `WIDTH`, 16, mel word width.
- `N_FRAMES`, 101, frames held.
- `MEL_BANDS`, 40, words per frame.
- `SPEC_ADDR_WIDTH`, `$clog2(N_FRAMES*MEL_BANDS)`, store address width.
- `FCNT_WIDTH`, `$clog2(N_FRAMES+1)`, frame counter width.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `clr` in 1: synchronous soft clear; same effect as `rst`.
- `mel_avail` in 1: input word valid. No backpressure.
- `mel_data` in `WIDTH`: input band word.
- `rd_start` in 1: dump request pulse.
- `rd_valid` out 1: output word valid.
- `rd_ready` in 1: downstream accepts the output word.
- `rd_data` out `WIDTH`: output word.
- `rd_last` out 1: final word of the dump.
- `rd_busy` out 1: high in ARMED or DUMP.
- `spec_full` out 1: `N_FRAMES` complete frames are stored.
- `frame_cnt` out `FCNT_WIDTH`: stored frames, saturating at `N_FRAMES`.
- `frame_done` out 1: one-cycle pulse when a frame completes.
- `overrun` out 1: sticky; set when a write overtakes the dump.

## Operation

Write side:
- Counters `wr_band` (0..`MEL_BANDS`-1) and `wr_frame` (0..`N_FRAMES`-1).
- On `mel_avail`, store `mel_data` at address `wr_frame*MEL_BANDS+wr_band`, then increment `wr_band`.
- When `wr_band` wraps from `MEL_BANDS`-1 to 0:
  - `wr_frame` increments, wrapping from `N_FRAMES`-1 to 0.
  - `frame_cnt` increments, saturating at `N_FRAMES`.
  - `frame_done` pulses on the next cycle.
- `spec_full` = (`frame_cnt` == `N_FRAMES`).
- Writes are always accepted in every state.

Read FSM:
- IDLE:
  - `rd_start` with `spec_full` = 1 goes to ARMED. `rd_start` with `spec_full` = 0 is ignored.
  - Accepting `rd_start` clears `overrun`.
- ARMED:
  - Wait until `wr_band` == 0 and no write is occurring this cycle.
  - Then latch `s = wr_frame` (the oldest complete frame), reset the read index `rl` and the write offset `wl` to 0, and go to DUMP.
  - If `wr_band` is already 0 on entry, ARMED lasts one cycle.
- DUMP:
  - Word `k` (0..`N_FRAMES*MEL_BANDS`-1) is read from address `((s + k/MEL_BANDS) mod N_FRAMES)*MEL_BANDS + k mod MEL_BANDS`.
  - `rl` advances on each `rd_valid && rd_ready`.
  - The handshake on `k` = `N_FRAMES*MEL_BANDS`-1 returns the FSM to IDLE.
- `rd_start` while in ARMED or DUMP is ignored.

Overrun:
- During DUMP, each write carries linear offset `wl` (writes since DUMP entry).
- If `wl >= rl` at that write, the slot has not been delivered yet: set `overrun`.
- The dump still completes with whatever data the store then holds. No abort.

Clear:
- `rst` or `clr` zeroes `wr_band`, `wr_frame`, `frame_cnt`, `overrun` and the FSM (to IDLE). This aborts any dump.
- Store contents are not cleared.
- A `mel_avail` in the same cycle as `rst`/`clr` is dropped.

## Timing

- Reset values: `rd_valid`, `rd_last`, `rd_busy`, `spec_full`, `frame_done` and `overrun` = 0; `frame_cnt` = 0; `rd_data` = 0.
- Store: synchronous RAM with 1-cycle read latency. A write is readable on the next cycle. A same-address read/write in the same cycle returns the old data.
- `rd_busy` rises the cycle after `rd_start` is accepted.
- The first `rd_valid` comes 2 cycles after DUMP entry.
- Sustained throughput is one word per cycle while `rd_ready` = 1. A prefetch/skid stage is required so there are no bubbles.
- While `rd_valid && !rd_ready`, `rd_data` and `rd_last` hold stable.
- `rd_last` is high only with the final word.
- `rd_valid` and `rd_busy` drop the cycle after the final handshake.
- `frame_done` fires 1 cycle after the last band write.
- `spec_full` updates in the same cycle as `frame_cnt`.

## Test plan

- Fill: after reset, write 101×40 words with value = linear index. `frame_cnt` steps to 101 and `spec_full` rises after word 4039. A dump then returns 0..4039 in order, `rd_last` on 4039, first `rd_valid` 3 cycles after `rd_start`.
- Wrap: write 103 frames (word = frame*40+band), then dump. The output starts at frame 2 band 0 (value 80) and ends at frame 102 band 39 (value 4119). `overrun` = 0.
- Armed deferral: after a full store, assert `rd_start` at `wr_band` = 17. `rd_busy` = 1 and no `rd_valid` until after the 23rd further write. The dump then starts at the frame that was oldest at that point.
- Backpressure: toggle `rd_ready` randomly at 50%. `rd_data` must stay stable while stalled, with no lost or duplicated words, and 4040 handshakes in total.
- Overrun: hold `rd_ready` = 0 during DUMP and write 1 frame. `overrun` rises on the first write. Release: 4040 words are delivered, and `overrun` stays set until the next accepted `rd_start`.
- Clear/ignore: `rd_start` with `frame_cnt` = 50 is ignored. `clr` mid-dump drops `rd_valid` and `rd_busy` the next cycle and zeroes `frame_cnt`, `spec_full` and `overrun`. A `mel_avail` coincident with `clr` is not counted.
